uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between two byte sources: req0 (CPU
//  store to the UART TX register) and req1 (peripheral/debug source).
//  Round-robin grant, valid/ready handshake to sources, start/busy handshake
//  to the transmitter, busy-timeout recovery and a sent-byte counter.
//  Sits between the CPU peripheral bus and the UART TX serializer.
// PARAMETERS
//  DATA_W        8   byte width to the transmitter
//  BUSY_TIMEOUT  16  cycles to wait for tx_busy rise after tx_start (>=2)
//  CNT_W         16  width of sent_cnt
// PORTS
//  sysclk       in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  req0_valid   in   1       source 0 has a byte
//  req0_data    in   DATA_W  source 0 byte
//  req0_ready   out  1       source 0 byte accepted this cycle (if valid)
//  req1_valid   in   1       source 1 has a byte
//  req1_data    in   DATA_W  source 1 byte
//  req1_ready   out  1       source 1 byte accepted this cycle (if valid)
//  tx_start     out  1       one-cycle start pulse to transmitter
//  tx_data      out  DATA_W  byte to transmitter, stable from START to IDLE
//  tx_busy      in   1       transmitter shifting a frame
//  grant_id     out  1       source of the byte currently in flight
//  arb_busy     out  1       high in every state except IDLE
//  timeout_err  out  1       one-cycle pulse on busy timeout
//  sent_cnt     out  CNT_W   bytes completed (WAIT_DONE->IDLE), wraps
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; tx_start=0, tx_data=0, grant_id=0,
//   arb_busy=0, timeout_err=0, sent_cnt=0, last_grant=1, timer=0.
//   Reset mid-frame drops the in-flight byte; no start pulse is reissued.
//  FSM states IDLE, START, WAIT_BUSY, WAIT_DONE:
//  - IDLE: reqN_ready combinational = (state==IDLE) & selected==N & reqN_valid.
//    Selection: only one valid -> that one; both valid -> the source !=
//    last_grant; none -> no ready. On accept: tx_data<=data, grant_id<=N,
//    last_grant<=N, -> START. At most one ready high per cycle.
//  - START: tx_start=1 for exactly this cycle; timer<=0; -> WAIT_BUSY.
//  - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Else timer++; when timer reaches
//    BUSY_TIMEOUT-1 with tx_busy still 0: timeout_err pulses 1 cycle,
//    -> IDLE, sent_cnt unchanged.
//  - WAIT_DONE: tx_busy=0 -> IDLE, sent_cnt<=sent_cnt+1 (wraps to 0 at max).
//  Latency: accept at cycle T, tx_start at T+1; earliest next accept is the
//   cycle after WAIT_DONE exits (both readies low while arb_busy=1).
//  tx_busy already high in IDLE (foreign frame) is ignored; WAIT_BUSY
//   sees it high and proceeds immediately (treated as our frame started).
//  Sources must hold valid/data until ready; dropping valid without ready
//   is legal and simply withdraws the request.
// TESTING
//  1 Reset: reset=0 async mid-cycle -> all outputs 0 immediately, readies 0.
//  2 Single: req0 0x41 valid, tx model busy 10 cycles from cycle after
//    start -> req0_ready 1 cycle, tx_start at T+1, tx_data=0x41, sent_cnt=1.
//  3 Contention: both valid (0x11 src0, 0x22 src1) held -> order 0x11,0x22,
//    0x11,0x22; grant_id alternates 0,1,0,1; never two readies together.
//  4 Timeout: tx_busy tied 0, req1 0x55 -> timeout_err pulse 16 cycles after
//    START, back in IDLE, sent_cnt unchanged, next byte accepted.
//  5 Reset mid-op: reset low during WAIT_DONE -> IDLE, sent_cnt=0, no extra
//    tx_start after release; next request served with grant to req0 first.
//  6 Wrap: CNT_W=4, send 17 bytes -> sent_cnt reads 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte sources,
// with a start/busy handshake to the serializer, busy-rise timeout and a sent-byte counter.
module uart_tx_arbiter #(
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              grant_id,
  output logic              arb_busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sent_cnt
);

  // state     | meaning
  // IDLE      | waiting for a source byte, readies may assert
  // START     | tx_start pulse, byte presented to the transmitter
  // WAIT_BUSY | waiting for tx_busy to rise, timer running
  // WAIT_DONE | frame in progress, waiting for tx_busy to fall
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;
  logic            last_grant;
  logic            sel_valid;
  logic            sel_id;
  logic            accept;
  logic            timer_hit;
  logic            cnt_inc;

  // With both sources pending, the one not served last wins.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_grant;
    end else begin
      sel_id = req1_valid;
    end
  end

  assign accept     = (state == IDLE) & sel_valid;
  assign req0_ready = accept & ~sel_id;
  assign req1_ready = accept & sel_id;
  assign arb_busy   = (state != IDLE);
  assign timer_hit  = (timer == TW'(BUSY_TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
        end
      end
      START: begin
        tx_start  = 1'b1;
        timer_nxt = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer_hit) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so that source 0 wins the first contended grant.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      tx_data    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      sent_cnt   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (accept) begin
        tx_data    <= sel_id ? req1_data : req0_data;
        grant_id   <= sel_id;
        last_grant <= sel_id;
      end
      if (cnt_inc) begin
        sent_cnt <= sent_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations (reset, single, contention, timeout, wrap).
module tb_uart_tx_arbiter;

  localparam int TO = 16;
  localparam int CW = 4;

  logic       sysclk;
  logic       reset;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_id;
  logic       arb_busy;
  logic       timeout_err;
  logic [CW-1:0] sent_cnt;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.DATA_W(8), .BUSY_TIMEOUT(TO), .CNT_W(CW)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err),
    .sent_cnt    (sent_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for 10 cycles starting the cycle after tx_start.
  bit tx_auto = 1'b1;
  int busy_left = 0;
  always @(negedge sysclk) if (tx_auto && tx_start) busy_left = 10;
  always @(posedge sysclk) begin
    #1;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
  end

  // Monitor of observed activity for the directed checks.
  int cyc = 0;
  int last_acc_cyc = 0, last_start_cyc = 0, last_to_cyc = 0;
  int start_cnt = 0, r0_pulses = 0, to_pulses = 0, both_cnt = 0;
  logic [7:0] acc_q[$];
  logic       gid_q[$];
  always @(posedge sysclk) cyc++;
  always @(negedge sysclk) begin
    if (req0_ready) r0_pulses++;
    if (req0_ready || req1_ready) last_acc_cyc = cyc;
    if (req0_ready && req1_ready) both_cnt++;
    if (tx_start) begin
      last_start_cyc = cyc;
      start_cnt++;
      acc_q.push_back(tx_data);
      gid_q.push_back(grant_id);
    end
    if (timeout_err) begin
      last_to_cyc = cyc;
      to_pulses++;
    end
  end

  // Transaction model: a byte is either absent or in flight; m_age counts cycles
  // since acceptance, m_seen records that the transmitter picked the frame up.
  bit         m_inflight = 1'b0;
  int         m_age = 0;
  bit         m_seen = 1'b0;
  bit         m_last = 1'b1;
  logic [7:0] m_data = 8'h00;
  bit         m_gid = 1'b0;
  int         m_cnt = 0;
  bit e_r0, e_r1, e_start, e_to;
  always @(negedge sysclk) begin
    if (!reset) begin
      m_inflight = 1'b0;
      m_age = 0;
      m_seen = 1'b0;
      m_last = 1'b1;
      m_data = 8'h00;
      m_gid = 1'b0;
      m_cnt = 0;
    end else begin
      e_r0    = !m_inflight && req0_valid && (!req1_valid || m_last == 1'b1);
      e_r1    = !m_inflight && req1_valid && (!req0_valid || m_last == 1'b0);
      e_start = m_inflight && m_age == 1;
      e_to    = m_inflight && !m_seen && !tx_busy && m_age == TO + 1;
      chk("model req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("model req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("model tx_start", 32'(tx_start), 32'(e_start));
      chk("model timeout_err", 32'(timeout_err), 32'(e_to));
      chk("model arb_busy", 32'(arb_busy), 32'(m_inflight));
      chk("model tx_data", 32'(tx_data), 32'(m_data));
      chk("model grant_id", 32'(grant_id), 32'(m_gid));
      chk("model sent_cnt", 32'(sent_cnt), 32'(m_cnt % (1 << CW)));
      if (!m_inflight) begin
        if (e_r0 || e_r1) begin
          m_inflight = 1'b1;
          m_age = 1;
          m_seen = 1'b0;
          m_gid = e_r1;
          m_last = e_r1;
          m_data = e_r1 ? req1_data : req0_data;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (!m_seen) begin
        if (tx_busy) m_seen = 1'b1;
        else if (m_age == TO + 1) m_inflight = 1'b0;
        else m_age++;
      end else if (!tx_busy) begin
        m_inflight = 1'b0;
        m_cnt++;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge sysclk);
      if (!arb_busy) ok = 1'b1;
    end
    @(posedge sysclk);
    #1;
    chk("wait idle timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input int src, input logic [7:0] d);
    bit ok = 1'b0;
    if (src == 0) begin
      req0_valid = 1'b1;
      req0_data  = d;
    end else begin
      req1_valid = 1'b1;
      req1_data  = d;
    end
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge sysclk);
      if ((src == 0) ? req0_ready : req1_ready) ok = 1'b1;
    end
    @(posedge sysclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("send ready timeout", 32'(ok), 32'd1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sc;
    int r0b;
    bit ok;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    tx_busy = 1'b0;

    // Reset values, then an async reset landing in START.
    #3;
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst arb_busy", 32'(arb_busy), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst timeout_err", 32'(timeout_err), 32'd0);
    chk("rst sent_cnt", 32'(sent_cnt), 32'd0);
    chk("rst readies", 32'({req0_ready, req1_ready}), 32'd0);
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h99;
    @(posedge sysclk);
    #1 req0_valid = 1'b0;
    chk("pre-rst tx_start", 32'(tx_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async tx_start", 32'(tx_start), 32'd0);
    chk("async arb_busy", 32'(arb_busy), 32'd0);
    chk("async tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b1;
    chk("async no start", 32'(start_cnt), 32'd0);

    // Single byte from source 0.
    r0b = r0_pulses;
    send(0, 8'h41);
    chk("single latency", 32'(last_start_cyc - last_acc_cyc), 32'd1);
    chk("single tx_data", 32'(acc_q[acc_q.size()-1]), 32'h41);
    chk("single ready pulses", 32'(r0_pulses - r0b), 32'd1);
    chk("single sent_cnt", 32'(sent_cnt), 32'd1);

    // Timeout: transmitter never goes busy.
    tx_auto = 1'b0;
    send(1, 8'h55);
    chk("timeout distance", 32'(last_to_cyc - last_start_cyc), 32'd16);
    chk("timeout pulses", 32'(to_pulses), 32'd1);
    chk("timeout sent_cnt", 32'(sent_cnt), 32'd1);
    chk("timeout idle", 32'(arb_busy), 32'd0);
    tx_auto = 1'b1;
    send(1, 8'h56);
    chk("after timeout sent_cnt", 32'(sent_cnt), 32'd2);

    // Contention: both held, expect strict alternation starting with source 0.
    acc_q.delete();
    gid_q.delete();
    req0_valid = 1'b1;
    req0_data = 8'h11;
    req1_valid = 1'b1;
    req1_data = 8'h22;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge sysclk);
      if (req0_ready || req1_ready) n++;
    end
    @(posedge sysclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("contention accepts", 32'(n), 32'd4);
    wait_idle();
    chk("contention count", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      chk("contention byte0", 32'(acc_q[0]), 32'h11);
      chk("contention byte1", 32'(acc_q[1]), 32'h22);
      chk("contention byte2", 32'(acc_q[2]), 32'h11);
      chk("contention byte3", 32'(acc_q[3]), 32'h22);
      chk("contention gids", 32'({gid_q[0], gid_q[1], gid_q[2], gid_q[3]}), 32'b0101);
    end
    chk("never two readies", 32'(both_cnt), 32'd0);
    chk("contention sent_cnt", 32'(sent_cnt), 32'd6);

    // Reset during WAIT_DONE.
    req0_valid = 1'b1;
    req0_data = 8'h77;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge sysclk);
      if (req0_ready) ok = 1'b1;
    end
    @(posedge sysclk);
    #1 req0_valid = 1'b0;
    chk("midop accept", 32'(ok), 32'd1);
    repeat (4) @(posedge sysclk);
    #2;
    chk("midop in frame", 32'({arb_busy, tx_busy}), 32'b11);
    reset = 1'b0;
    #1;
    chk("midop arb_busy", 32'(arb_busy), 32'd0);
    chk("midop sent_cnt", 32'(sent_cnt), 32'd0);
    chk("midop tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b1;
    sc = start_cnt;
    repeat (12) @(posedge sysclk);
    #1;
    chk("midop no restart", 32'(start_cnt - sc), 32'd0);
    req0_valid = 1'b1;
    req0_data = 8'h31;
    req1_valid = 1'b1;
    req1_data = 8'h32;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge sysclk);
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        chk("midop first grant", 32'({req0_ready, req1_ready}), 32'b10);
      end
    end
    @(posedge sysclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("midop served", 32'(ok), 32'd1);
    wait_idle();
    chk("midop byte", 32'(acc_q[acc_q.size()-1]), 32'h31);
    chk("midop sent_cnt after", 32'(sent_cnt), 32'd1);

    // Counter wrap with a 4-bit counter.
    @(posedge sysclk);
    #3 reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b1;
    for (int i = 0; i < 17; i++) send(i % 2, 8'(i + 1));
    chk("wrap sent_cnt", 32'(sent_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
